alu_issue: RTL and testbench
============================

ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the issued-instruction counter.
REQ-002 SHALL have port clk, input, 1: sole clock, all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1: instr/rs_data/rt_data valid.
REQ-005 SHALL have port in_ready, output, 1: stage accepts input this cycle.
REQ-006 SHALL have port instr, input, 32: MIPS instruction word.
REQ-007 SHALL have port rs_data, input, 32: register-file value of instr[25:21].
REQ-008 SHALL have port rt_data, input, 32: register-file value of instr[20:16].
REQ-009 SHALL have port out_valid, output, 1: ALU operands valid.
REQ-010 SHALL have port out_ready, input, 1: downstream ALU stage consumes this cycle.
REQ-011 SHALL have port alu_op, output, 4: ALU operation code.
REQ-012 SHALL have port lt and rt, output, 32 each: ALU left/right operands.
REQ-013 SHALL have port dest, output, 5: writeback register index, 0 = no writeback.
REQ-014 SHALL have port illegal, output, 1: issued instruction not decodable.
REQ-015 SHALL have port issue_cnt, output, CNT_W: count of completed output transfers.

Function
REQ-016 SHALL use alu_op encoding AND 0000, OR 0001, ADD 0010, NOR 1100, SUB 0110, SLT 0111.
REQ-017 SHALL decode R-type (opcode 000000) funct 100000/100001 ADD, 100010/100011 SUB, 100100 AND, 100101 OR, 100111 NOR, 101010 SLT; lt=rs_data, rt=rt_data, dest=instr[15:11].
REQ-018 SHALL decode addi 001000/addiu 001001 ADD, slti 001010 SLT, lw 100011/sw 101011 ADD with rt = sign-extended imm16; andi 001100 AND, ori 001101 OR with rt = zero-extended imm16; lt=rs_data.
REQ-019 SHALL decode lui 001111 as OR with lt=0, rt={imm16,16'h0}.
REQ-020 SHALL decode beq 000100 as SUB with lt=rs_data, rt=rt_data, dest=0.
REQ-021 SHALL set dest=instr[20:16] for addi/addiu/slti/andi/ori/lui/lw and dest=0 for sw, beq.
REQ-022 SHALL, for any other opcode or funct, issue alu_op=0000, lt=0, rt=0, dest=0, illegal=1; illegal=0 otherwise.
REQ-023 SHALL force dest=0 when the decoded destination index is 0.
REQ-024 SHALL register decode results: accepted input appears on outputs no earlier than the next cycle (latency 1 when output stage empty).
REQ-025 SHALL implement a 2-entry skid buffer: main output register plus one skid register.
REQ-026 SHALL drive in_ready = ~skid_full, from a flop only, with no combinational path from out_ready.
REQ-027 SHALL define transfer in = in_valid & in_ready; transfer out = out_valid & out_ready.
REQ-028 SHALL, on transfer in with main empty or main draining (transfer out) and skid empty, load main directly.
REQ-029 SHALL, on transfer in with main full and not draining, load skid; skid_full=1.
REQ-030 SHALL, on transfer out with skid full, move skid to main and clear skid_full; no input accepted that cycle since in_ready=0.
REQ-031 SHALL hold all output fields stable while out_valid=1 and out_ready=0.
REQ-032 SHALL never drop, duplicate, or reorder instructions.
REQ-033 SHALL increment issue_cnt by 1 per transfer out, wrapping from all-ones to 0.

Reset
REQ-034 SHALL, while rst_n=0, immediately force out_valid=0, in_ready=1, skid_full=0, alu_op=0000, lt=0, rt=0, dest=0, illegal=0, issue_cnt=0.
REQ-035 SHALL discard any buffered instruction when reset asserts mid-operation; first accept after release at the first rising edge with rst_n=1.

Verification
REQ-036 SHALL check: add $3,$1,$2 (0x00221820), rs=5, rt=7, out_ready=1 -> next cycle out_valid=1, alu_op=0010, lt=5, rt=7, dest=3.
REQ-037 SHALL check: addi $4,$1,-1 (0x2024FFFF), rs=10 -> alu_op=0010, lt=10, rt=0xFFFFFFFF, dest=4; ori same imm -> rt=0x0000FFFF, alu_op=0001.
REQ-038 SHALL check: lui $5,0x1234 (0x3C051234) -> alu_op=0001, lt=0, rt=0x12340000, dest=5; opcode 111111 -> illegal=1, dest=0.
REQ-039 SHALL check backpressure: three back-to-back valid inputs A,B,C with out_ready=0 -> A in main, B in skid, in_ready=0 next cycle, C held; raise out_ready -> A,B,C emerge in order, issue_cnt=3.
REQ-040 SHALL check reset mid-stream: main and skid full, rst_n low asynchronously between edges -> out_valid=0, in_ready=1, issue_cnt=0 before next edge.
REQ-041 SHALL check wrap: CNT_W=4, 16 transfers -> issue_cnt returns to 0.

Source files
------------

// File: rtl/alu_issue.sv
// alu_issue: MIPS ALU-operand issue stage.
// Decodes an instruction and its register-file operands into an ALU opcode,
// left/right operands and a writeback index. The result is registered behind
// a 2-entry skid buffer (main output register plus one skid register), so
// in_ready depends only on a flop and never on out_ready.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   instr/rs_data/rt_data valid
//   in_ready   stage accepts input this cycle (= ~skid_full)
//   instr      MIPS instruction word
//   rs_data    register-file value of instr[25:21]
//   rt_data    register-file value of instr[20:16]
//   out_valid  ALU operands valid
//   out_ready  downstream consumes this cycle
//   alu_op     ALU operation code
//   lt, rt     ALU left/right operands
//   dest       writeback register index, 0 = no writeback
//   illegal    issued instruction was not decodable
//   issue_cnt  count of completed output transfers (wraps)
module alu_issue #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [31:0]      rs_data,
  input  logic [31:0]      rt_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       alu_op,
  output logic [31:0]      lt,
  output logic [31:0]      rt,
  output logic [4:0]       dest,
  output logic             illegal,
  output logic [CNT_W-1:0] issue_cnt
);

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_NOR = 4'b1100
  } alu_op_e;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] lt;
    logic [31:0] rt;
    logic [4:0]  dest;
    logic        ill;
  } issue_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic [31:0] imm_sext;
  logic [31:0] imm_zext;

  // rs index is implied by rs_data; the field itself is not needed here.
  logic unused_rs_idx;

  issue_t  dec;
  alu_op_e dec_op;
  logic    dec_legal;

  issue_t  main_q;
  issue_t  skid_q;
  logic    main_valid;
  logic    skid_full;
  logic [CNT_W-1:0] cnt_q;

  logic    xfer_in;
  logic    xfer_out;

  assign opcode        = instr[31:26];
  assign funct         = instr[5:0];
  assign imm           = instr[15:0];
  assign imm_sext      = {{16{imm[15]}}, imm};
  assign imm_zext      = {16'h0000, imm};
  assign unused_rs_idx = ^instr[25:21];

  always_comb begin
    dec       = '0;
    dec_op    = ALU_AND;
    dec_legal = 1'b1;
    unique case (opcode)
      6'b000000: begin
        dec.lt   = rs_data;
        dec.rt   = rt_data;
        dec.dest = instr[15:11];
        unique case (funct)
          6'b100000, 6'b100001: dec_op = ALU_ADD;
          6'b100010, 6'b100011: dec_op = ALU_SUB;
          6'b100100:            dec_op = ALU_AND;
          6'b100101:            dec_op = ALU_OR;
          6'b100111:            dec_op = ALU_NOR;
          6'b101010:            dec_op = ALU_SLT;
          default:              dec_legal = 1'b0;
        endcase
      end
      6'b001000, 6'b001001, 6'b100011: begin
        dec_op   = ALU_ADD;
        dec.lt   = rs_data;
        dec.rt   = imm_sext;
        dec.dest = instr[20:16];
      end
      6'b001010: begin
        dec_op   = ALU_SLT;
        dec.lt   = rs_data;
        dec.rt   = imm_sext;
        dec.dest = instr[20:16];
      end
      6'b101011: begin
        dec_op = ALU_ADD;
        dec.lt = rs_data;
        dec.rt = imm_sext;
      end
      6'b001100: begin
        dec_op   = ALU_AND;
        dec.lt   = rs_data;
        dec.rt   = imm_zext;
        dec.dest = instr[20:16];
      end
      6'b001101: begin
        dec_op   = ALU_OR;
        dec.lt   = rs_data;
        dec.rt   = imm_zext;
        dec.dest = instr[20:16];
      end
      6'b001111: begin
        dec_op   = ALU_OR;
        dec.rt   = {imm, 16'h0000};
        dec.dest = instr[20:16];
      end
      6'b000100: begin
        dec_op = ALU_SUB;
        dec.lt = rs_data;
        dec.rt = rt_data;
      end
      default: dec_legal = 1'b0;
    endcase
    dec.op = dec_op;
    if (!dec_legal) begin
      dec     = '0;
      dec.ill = 1'b1;
    end
  end

  assign in_ready = ~skid_full;
  assign xfer_in  = in_valid & in_ready;
  assign xfer_out = main_valid & out_ready;

  // While the skid holds an entry, in_ready is low, so the only possible
  // move is skid -> main on a drain; otherwise input lands in main when main
  // is empty or draining, and in the skid when main is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_valid <= 1'b0;
      skid_full  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      if (xfer_out) begin
        cnt_q <= cnt_q + CNT_ONE;
      end
      if (skid_full) begin
        if (xfer_out) begin
          main_q    <= skid_q;
          skid_full <= 1'b0;
        end
      end else if (xfer_in) begin
        if (!main_valid || xfer_out) begin
          main_q     <= dec;
          main_valid <= 1'b1;
        end else begin
          skid_q    <= dec;
          skid_full <= 1'b1;
        end
      end else if (xfer_out) begin
        main_valid <= 1'b0;
      end
    end
  end

  assign out_valid = main_valid;
  assign alu_op    = main_q.op;
  assign lt        = main_q.lt;
  assign rt        = main_q.rt;
  assign dest      = main_q.dest;
  assign illegal   = main_q.ill;
  assign issue_cnt = cnt_q;

endmodule

// File: tb/tb_alu_issue.sv
// Directed testbench for alu_issue (CNT_W = 4 so counter wrap is reachable).
module tb_alu_issue;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  alu_op;
  logic [31:0] lt;
  logic [31:0] rt;
  logic [4:0]  dest;
  logic        illegal;
  logic [3:0]  issue_cnt;

  int unsigned total;
  int unsigned bad;
  logic [3:0]  exp_cnt;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] rs;
    logic [31:0] rtd;
    logic [3:0]  op;
    logic [31:0] lt;
    logic [31:0] rt;
    logic [4:0]  dest;
    logic        ill;
  } vec_t;

  vec_t vecs [16];

  alu_issue #(.CNT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .rs_data   (rs_data),
    .rt_data   (rt_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_op    (alu_op),
    .lt        (lt),
    .rt        (rt),
    .dest      (dest),
    .illegal   (illegal),
    .issue_cnt (issue_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    tick();
    #2 rst_n = 1'b1;
    tick();
    exp_cnt = 4'd0;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    instr     = '0;
    rs_data   = '0;
    rt_data   = '0;
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    total++; if (issue_cnt !== 4'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", issue_cnt); end
    total++; if ({alu_op, lt, rt, dest, illegal} !== '0) begin bad++; $display("FAIL reset_fields got op=%h lt=%h rt=%h dest=%0d ill=%0b exp all zero", alu_op, lt, rt, dest, illegal); end
    #2 rst_n = 1'b1;
    tick();
    exp_cnt = 4'd0;
  endtask

  task automatic test_decode();
    vecs[0]  = '{32'h00221820, 32'd5,      32'd7,    4'b0010, 32'd5,      32'd7,        5'd3, 1'b0};
    vecs[1]  = '{32'h00223022, 32'd9,      32'd4,    4'b0110, 32'd9,      32'd4,        5'd6, 1'b0};
    vecs[2]  = '{32'h0022382A, 32'd1,      32'd2,    4'b0111, 32'd1,      32'd2,        5'd7, 1'b0};
    vecs[3]  = '{32'h00224027, 32'hF0,     32'h0F,   4'b1100, 32'hF0,     32'h0F,       5'd8, 1'b0};
    vecs[4]  = '{32'h00224824, 32'd3,      32'd6,    4'b0000, 32'd3,      32'd6,        5'd9, 1'b0};
    vecs[5]  = '{32'h00220020, 32'd1,      32'd1,    4'b0010, 32'd1,      32'd1,        5'd0, 1'b0};
    vecs[6]  = '{32'h2024FFFF, 32'd10,     32'h55,   4'b0010, 32'd10,     32'hFFFFFFFF, 5'd4, 1'b0};
    vecs[7]  = '{32'h3424FFFF, 32'd10,     32'h55,   4'b0001, 32'd10,     32'h0000FFFF, 5'd4, 1'b0};
    vecs[8]  = '{32'h3C051234, 32'h99,     32'h55,   4'b0001, 32'd0,      32'h12340000, 5'd5, 1'b0};
    vecs[9]  = '{32'hFC000000, 32'h77,     32'h88,   4'b0000, 32'd0,      32'd0,        5'd0, 1'b1};
    vecs[10] = '{32'hAC220008, 32'h100,    32'd5,    4'b0010, 32'h100,    32'd8,        5'd0, 1'b0};
    vecs[11] = '{32'h10220003, 32'd3,      32'd3,    4'b0110, 32'd3,      32'd3,        5'd0, 1'b0};
    vecs[12] = '{32'h00221800, 32'd4,      32'd5,    4'b0000, 32'd0,      32'd0,        5'd0, 1'b1};
    vecs[13] = '{32'h30248000, 32'hFFFF,   32'h55,   4'b0000, 32'hFFFF,   32'h00008000, 5'd4, 1'b0};
    vecs[14] = '{32'h28248000, 32'd2,      32'h55,   4'b0111, 32'd2,      32'hFFFF8000, 5'd4, 1'b0};
    vecs[15] = '{32'h8C24FFFC, 32'h1000,   32'h55,   4'b0010, 32'h1000,   32'hFFFFFFFC, 5'd4, 1'b0};
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      instr    = vecs[i].instr;
      rs_data  = vecs[i].rs;
      rt_data  = vecs[i].rtd;
      tick();
      in_valid = 1'b0;
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL dec%0d_valid got=%0b exp=1", i, out_valid); end
      total++; if (alu_op !== vecs[i].op) begin bad++; $display("FAIL dec%0d_op got=%b exp=%b", i, alu_op, vecs[i].op); end
      total++; if (lt !== vecs[i].lt) begin bad++; $display("FAIL dec%0d_lt got=%h exp=%h", i, lt, vecs[i].lt); end
      total++; if (rt !== vecs[i].rt) begin bad++; $display("FAIL dec%0d_rt got=%h exp=%h", i, rt, vecs[i].rt); end
      total++; if (dest !== vecs[i].dest) begin bad++; $display("FAIL dec%0d_dest got=%0d exp=%0d", i, dest, vecs[i].dest); end
      total++; if (illegal !== vecs[i].ill) begin bad++; $display("FAIL dec%0d_ill got=%0b exp=%0b", i, illegal, vecs[i].ill); end
      tick();
      exp_cnt = exp_cnt + 4'd1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL dec%0d_drain got=%0b exp=0", i, out_valid); end
      total++; if (issue_cnt !== exp_cnt) begin bad++; $display("FAIL dec%0d_cnt got=%0d exp=%0d", i, issue_cnt, exp_cnt); end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    instr = 32'h20010001; rs_data = 32'd0; rt_data = 32'd0;
    tick();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_after_a got=%0b exp=1", in_ready); end
    instr = 32'h20020002;
    tick();
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_after_b got=%0b exp=0", in_ready); end
    instr = 32'h20030003;
    total++; if ({out_valid, rt, dest} !== {1'b1, 32'd1, 5'd1}) begin bad++; $display("FAIL bp_main_a got v=%0b rt=%0d dest=%0d exp v=1 rt=1 dest=1", out_valid, rt, dest); end
    tick();
    total++; if ({out_valid, rt, dest, in_ready} !== {1'b1, 32'd1, 5'd1, 1'b0}) begin bad++; $display("FAIL bp_hold_a got v=%0b rt=%0d dest=%0d rdy=%0b exp v=1 rt=1 dest=1 rdy=0", out_valid, rt, dest, in_ready); end
    out_ready = 1'b1;
    tick();
    total++; if ({out_valid, rt, dest, in_ready} !== {1'b1, 32'd2, 5'd2, 1'b1}) begin bad++; $display("FAIL bp_out_b got v=%0b rt=%0d dest=%0d rdy=%0b exp v=1 rt=2 dest=2 rdy=1", out_valid, rt, dest, in_ready); end
    total++; if (issue_cnt !== 4'd1) begin bad++; $display("FAIL bp_cnt1 got=%0d exp=1", issue_cnt); end
    tick();
    in_valid = 1'b0;
    total++; if ({out_valid, rt, dest} !== {1'b1, 32'd3, 5'd3}) begin bad++; $display("FAIL bp_out_c got v=%0b rt=%0d dest=%0d exp v=1 rt=3 dest=3", out_valid, rt, dest); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_empty got=%0b exp=0", out_valid); end
    total++; if (issue_cnt !== 4'd3) begin bad++; $display("FAIL bp_cnt3 got=%0d exp=3", issue_cnt); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    instr = 32'h20040004; rs_data = 32'd0; rt_data = 32'd0;
    tick();
    instr = 32'h20050005;
    tick();
    total++; if ({out_valid, in_ready} !== 2'b10) begin bad++; $display("FAIL rm_full got v=%0b rdy=%0b exp v=1 rdy=0", out_valid, in_ready); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rm_valid got=%0b exp=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rm_ready got=%0b exp=1", in_ready); end
    total++; if (issue_cnt !== 4'd0) begin bad++; $display("FAIL rm_cnt got=%0d exp=0", issue_cnt); end
    total++; if ({alu_op, lt, rt, dest, illegal} !== '0) begin bad++; $display("FAIL rm_fields got op=%h rt=%h dest=%0d exp zero", alu_op, rt, dest); end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    #2 rst_n = 1'b1;
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rm_no_ghost got=%0b exp=0", out_valid); end
    in_valid = 1'b1;
    instr = 32'h20060006;
    tick();
    in_valid = 1'b0;
    total++; if ({out_valid, rt, dest} !== {1'b1, 32'd6, 5'd6}) begin bad++; $display("FAIL rm_first got v=%0b rt=%0d dest=%0d exp v=1 rt=6 dest=6", out_valid, rt, dest); end
    tick();
  endtask

  task automatic test_wrap();
    do_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    instr = 32'h00221820; rs_data = 32'd1; rt_data = 32'd2;
    for (int i = 0; i < 16; i++) tick();
    in_valid = 1'b0;
    total++; if (issue_cnt !== 4'd15) begin bad++; $display("FAIL wrap_cnt15 got=%0d exp=15", issue_cnt); end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL wrap_last_valid got=%0b exp=1", out_valid); end
    tick();
    total++; if (issue_cnt !== 4'd0) begin bad++; $display("FAIL wrap_cnt0 got=%0d exp=0", issue_cnt); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL wrap_empty got=%0b exp=0", out_valid); end
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    exp_cnt = 4'd0;
    test_reset();
    test_decode();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
